// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall vectors,
// exception codes, controller states and the stall merge helper.
package pipe_ctrl_pkg;

    localparam logic RST_ENABLE  = 1'b0;
    localparam logic CHIP_ENABLE = 1'b1;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXC_NONE         = 32'h0000_0000;
    localparam logic [31:0] EXC_INTERRUPT    = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
    localparam logic [31:0] EXC_INVALID_INST = 32'h0000_000a;
    localparam logic [31:0] EXC_OVERFLOW     = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_BLANK = 2'd2
    } ctrl_state_e;

    // The deepest requesting stage freezes itself and everything upstream.
    function automatic logic [5:0] stall_merge(
        input logic id,
        input logic ex,
        input logic mem
    );
        logic [5:0] v;
        v = STALL_NONE;
        priority case (1'b1)
            mem:     v = STALL_MEM;
            ex:      v = STALL_EX;
            id:      v = STALL_ID;
            default: v = STALL_NONE;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles and raises a
// sticky flag once the run reaches the timeout.
module stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stalled,
    input  logic clear,
    output logic stall_timeout
);

    localparam logic [15:0] LIMIT = 16'(STALL_TIMEOUT - 1);

    logic [15:0] cnt;
    logic        counting;

    assign counting = stalled && !clear;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            cnt <= 16'd0;
        end else if (!counting) begin
            cnt <= 16'd0;
        end else if (cnt != 16'hffff) begin
            cnt <= cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            stall_timeout <= 1'b0;
        end else if (counting && (cnt >= LIMIT)) begin
            stall_timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall merge, exception/eret flush
// sequencing with a blanking window, and the stall watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
    parameter int unsigned BLANK_CYCLES  = 2,
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout
);

    localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYCLES - 1);

    ctrl_state_e state;
    ctrl_state_e state_nxt;
    logic [3:0]  blank_cnt;
    logic [3:0]  blank_nxt;
    logic        accept;
    logic [31:0] target;

    // MEM holds a pending exception stable until its bus stall clears.
    assign accept = (state == ST_RUN)
                 && (excepttype_i != EXC_NONE)
                 && !stallreq_mem;

    assign target = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;

    always_comb begin
        stall = STALL_NONE;
        if ((rst != RST_ENABLE) && (state != ST_FLUSH)) begin
            stall = stall_merge(stallreq_id, stallreq_ex, stallreq_mem);
        end
    end

    always_comb begin
        state_nxt = state;
        blank_nxt = blank_cnt;
        unique case (state)
            ST_RUN: begin
                if (accept) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_nxt = ST_BLANK;
                blank_nxt = BLANK_LOAD;
            end
            ST_BLANK: begin
                if (blank_cnt == 4'd0) begin
                    state_nxt = ST_RUN;
                end else begin
                    blank_nxt = blank_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                blank_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state     <= ST_RUN;
            blank_cnt <= 4'd0;
            flush     <= 1'b0;
            new_pc    <= 32'd0;
        end else begin
            state     <= state_nxt;
            blank_cnt <= blank_nxt;
            flush     <= accept;
            if (accept) begin
                new_pc <= target;
            end
        end
    end

    stall_watchdog #(
        .STALL_TIMEOUT(STALL_TIMEOUT)
    ) u_watchdog (
        .clk          (clk),
        .rst          (rst),
        .stalled      (stall != STALL_NONE),
        .clear        (state == ST_FLUSH),
        .stall_timeout(stall_timeout)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle vector table plus
// hand-written asynchronous reset sequences.
module tb_pipe_ctrl;

    typedef struct {
        logic        id;
        logic        ex;
        logic        mem;
        logic [31:0] exc;
        logic [31:0] epc;
        logic [5:0]  st;
        logic        fl;
        logic [31:0] pc;
        logic        to;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;

    int checks;
    int failures;
    vec_t vq[$];

    pipe_ctrl #(
        .EXC_VECTOR   (32'h0000_0020),
        .BLANK_CYCLES (2),
        .STALL_TIMEOUT(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excepttype_i (excepttype_i),
        .cp0_epc_i    (cp0_epc_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_timeout(stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t r(
        input logic id, input logic ex, input logic mem,
        input logic [31:0] exc, input logic [31:0] epc,
        input logic [5:0] st, input logic fl,
        input logic [31:0] pc, input logic to
    );
        vec_t v;
        v.id = id; v.ex = ex; v.mem = mem;
        v.exc = exc; v.epc = epc;
        v.st = st; v.fl = fl; v.pc = pc; v.to = to;
        return v;
    endfunction

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        stallreq_id = 1'b0;
        stallreq_ex = 1'b0;
        stallreq_mem = 1'b0;
        excepttype_i = 32'd0;
        cp0_epc_i = 32'd0;

        // idle and stall priority
        vq.push_back(r(0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0));
        vq.push_back(r(1,1,0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 0));
        vq.push_back(r(1,1,1, 32'h0, 32'h0, 6'b011111, 0, 32'h0, 0));
        vq.push_back(r(1,0,0, 32'h0, 32'h0, 6'b000111, 0, 32'h0, 0));
        vq.push_back(r(0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0));
        // syscall, repeats ignored through flush and blank window
        vq.push_back(r(0,0,0, 32'h8, 32'h0, 6'b000000, 0, 32'h0, 0));
        vq.push_back(r(0,0,0, 32'h8, 32'h0, 6'b000000, 1, 32'h20, 0));
        vq.push_back(r(0,0,0, 32'h8, 32'h0, 6'b000000, 0, 32'h20, 0));
        vq.push_back(r(0,0,0, 32'h8, 32'h0, 6'b000000, 0, 32'h20, 0));
        vq.push_back(r(0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h20, 0));
        // eret with an ID stall that must not block it
        vq.push_back(r(1,0,0, 32'he, 32'h00401234, 6'b000111, 0, 32'h20, 0));
        vq.push_back(r(0,1,0, 32'h0, 32'h0, 6'b000000, 1, 32'h00401234, 0));
        vq.push_back(r(0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h00401234, 0));
        vq.push_back(r(0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h00401234, 0));
        vq.push_back(r(0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h00401234, 0));
        // overflow deferred by a MEM stall
        vq.push_back(r(0,0,1, 32'hc, 32'h0, 6'b011111, 0, 32'h00401234, 0));
        vq.push_back(r(0,0,1, 32'hc, 32'h0, 6'b011111, 0, 32'h00401234, 0));
        vq.push_back(r(0,0,1, 32'hc, 32'h0, 6'b011111, 0, 32'h00401234, 0));
        vq.push_back(r(0,0,0, 32'hc, 32'h0, 6'b000000, 0, 32'h00401234, 0));
        vq.push_back(r(0,0,0, 32'h0, 32'h0, 6'b000000, 1, 32'h20, 0));
        vq.push_back(r(0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h20, 0));
        vq.push_back(r(0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h20, 0));
        vq.push_back(r(0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h20, 0));
        // watchdog: flag appears only after the 8th stalled cycle
        for (int k = 0; k < 8; k++) begin
            vq.push_back(r(0,1,0, 32'h0, 32'h0, 6'b001111, 0, 32'h20, 0));
        end
        vq.push_back(r(0,1,0, 32'h0, 32'h0, 6'b001111, 0, 32'h20, 1));
        vq.push_back(r(0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h20, 1));

        // reset state, stall masked while in reset
        #1 stallreq_mem = 1'b1;
        #1;
        chk("reset_stall", {26'd0, stall}, 32'h0);
        chk("reset_flush", {31'd0, flush}, 32'h0);
        chk("reset_new_pc", new_pc, 32'h0);
        chk("reset_timeout", {31'd0, stall_timeout}, 32'h0);
        @(negedge clk);
        stallreq_mem = 1'b0;
        rst = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            stallreq_id = vq[i].id;
            stallreq_ex = vq[i].ex;
            stallreq_mem = vq[i].mem;
            excepttype_i = vq[i].exc;
            cp0_epc_i = vq[i].epc;
            #1;
            chk($sformatf("row%0d_stall", i), {26'd0, stall}, {26'd0, vq[i].st});
            chk($sformatf("row%0d_flush", i), {31'd0, flush}, {31'd0, vq[i].fl});
            chk($sformatf("row%0d_new_pc", i), new_pc, vq[i].pc);
            chk($sformatf("row%0d_timeout", i), {31'd0, stall_timeout},
                {31'd0, vq[i].to});
        end

        // async reset in the middle of a flush
        @(negedge clk);
        stallreq_id = 1'b0;
        stallreq_ex = 1'b0;
        excepttype_i = 32'h8;
        @(posedge clk);
        #2;
        excepttype_i = 32'h0;
        chk("pre_rst_flush", {31'd0, flush}, 32'h1);
        #1 rst = 1'b0;
        stallreq_mem = 1'b1;
        #1;
        chk("mid_flush_rst_flush", {31'd0, flush}, 32'h0);
        chk("mid_flush_rst_new_pc", new_pc, 32'h0);
        chk("mid_flush_rst_timeout", {31'd0, stall_timeout}, 32'h0);
        chk("mid_flush_rst_stall", {26'd0, stall}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        stallreq_mem = 1'b0;
        #1;
        chk("post_rst_stall", {26'd0, stall}, 32'h0);

        // async reset in the blank window must return the FSM to RUN
        excepttype_i = 32'h8;
        @(posedge clk);
        #2;
        excepttype_i = 32'h0;
        chk("second_flush", {31'd0, flush}, 32'h1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 rst = 1'b1;
        excepttype_i = 32'he;
        cp0_epc_i = 32'h0000_0abc;
        @(negedge clk);
        chk("blank_rst_flush", {31'd0, flush}, 32'h0);
        chk("blank_rst_new_pc", new_pc, 32'h0);
        @(negedge clk);
        excepttype_i = 32'h0;
        cp0_epc_i = 32'h0;
        chk("after_blank_rst_flush", {31'd0, flush}, 32'h1);
        chk("after_blank_rst_new_pc", new_pc, 32'h0000_0abc);
        @(negedge clk);
        chk("after_blank_rst_one_cycle", {31'd0, flush}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the five-stage core.
- Merges per-stage stall requests into the 6-bit stall vector that drives the PC register and the IF/ID/EX/MEM/WB pipeline registers.
- Sequences exception/eret flushes: it registers the target PC and asserts flush for exactly one cycle.
- Runs a stall watchdog that flags pipelines stuck in stall.

Parameters:
- EXC_VECTOR, 32'h00000020, PC loaded on any non-eret exception.
- BLANK_CYCLES, 2, cycles after a flush during which excepttype_i is ignored (range 1..15).
- STALL_TIMEOUT, 1024, consecutive stalled cycles before stall_timeout sets (range 2..65535).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- stallreq_id  input  1  ID stage requests stall (load-use hazard).
- stallreq_ex  input  1  EX stage requests stall (multi-cycle mul/div).
- stallreq_mem  input  1  MEM stage requests stall (bus not ready).
- excepttype_i  input  32  exception code from MEM stage; 0 means none.
- cp0_epc_i  input  32  current EPC from CP0.
- stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 means hold.
- flush  output  1  one-cycle pipeline flush, registered.
- new_pc  output  32  flush target, registered, valid while flush=1.
- stall_timeout  output  1  sticky watchdog flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - flush=0, new_pc=0, stall_timeout=0.
  - FSM=RUN, blank counter=0, watchdog counter=0.
  - stall=0 while reset is asserted.
- Stall vector is combinational from requests plus FSM state. Highest requesting stage wins:
  - stallreq_mem gives 6'b011111.
  - else stallreq_ex gives 6'b001111.
  - else stallreq_id gives 6'b000111.
  - else 6'b000000.
  - stall is forced to 0 while FSM=FLUSH.
- Exception accept condition: FSM=RUN, excepttype_i!=0, stallreq_mem=0. stallreq_id and stallreq_ex do not block acceptance.
- On accept in cycle N:
  - In cycle N+1: flush=1 and FSM=FLUSH.
  - new_pc = cp0_epc_i sampled in cycle N if excepttype_i==32'h0000000e (eret); otherwise new_pc = EXC_VECTOR.
- FSM states:
  - RUN → FLUSH on accept.
  - FLUSH (1 cycle) → BLANK; the blank counter loads BLANK_CYCLES-1.
  - BLANK: excepttype_i is ignored; the counter decrements each cycle; → RUN when the counter is 0.
  - flush=1 only in FLUSH. new_pc holds its value outside FLUSH.
- Exception arriving while stallreq_mem=1: deferred. MEM holds excepttype_i stable; the exception is accepted in the first cycle in which stallreq_mem=0.
- Watchdog:
  - The counter increments (saturating at 16 bits) every cycle in which stall!=0.
  - It clears in any cycle with stall==0.
  - When the counter reaches STALL_TIMEOUT-1 while stall!=0, stall_timeout sets and stays set until reset.
  - A flush cycle counts as unstalled.
- Asynchronous reset mid-FLUSH or mid-BLANK immediately returns every register to its reset value.
- Stall requests are not registered: a request in cycle N affects stall in cycle N.

Decomposition:
- Shared defines package holds:
  - Stall vector constants STALL_NONE/ID/EX/MEM.
  - Exception codes (interrupt 32'h1, syscall 32'h8, invalid inst 32'ha, trap 32'hd, overflow 32'hc, eret 32'he).
  - FSM state encodings, alongside the existing RstEnable/ChipEnable macros.
- One natural sub-module, stall_watchdog: counter, compare and sticky flag, with inputs stalled and clear.

Test Plan:
1. Reset then idle. Release rst with all inputs 0 → stall=0, flush=0, new_pc=0, stall_timeout=0.
2. Stall priority. Assert stallreq_id and stallreq_ex in the same cycle → stall=6'b001111. Then add stallreq_mem → stall=6'b011111 in that same cycle.
3. Syscall. excepttype_i=32'h8 for one cycle → next cycle flush=1, new_pc=32'h00000020, stall=0. A repeat of 32'h8 during the following 2 cycles is ignored.
4. Eret. cp0_epc_i=32'h00401234, excepttype_i=32'he → next cycle flush=1, new_pc=32'h00401234. Flush lasts exactly 1 cycle.
5. Deferred exception. excepttype_i=32'hc with stallreq_mem=1 for 3 cycles, then stallreq_mem=0 → no flush during the 3 cycles; flush=1 in the cycle after stallreq_mem falls.
6. Watchdog. STALL_TIMEOUT=8, hold stallreq_ex high → stall_timeout=1 after the 8th stalled cycle and stays 1 after the request drops. Pulse rst low mid-sequence → stall_timeout=0 asynchronously.
